// File: rtl/issue_queue_pkg.sv
// Shared constants and types for the dual-lane issue queue between decode and issue.
package issue_queue_pkg;

   localparam int unsigned IQ_DEPTH  = 8;
   localparam int unsigned IQ_DATA_W = 64;
   localparam int unsigned IQ_PTR_W  = $clog2(IQ_DEPTH);

   typedef struct packed {
      logic [IQ_DATA_W-1:0] payload;
   } iq_entry_t;

   typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
   typedef logic [IQ_PTR_W:0]   iq_cnt_t;

   function automatic logic [1:0] laneCount(input logic [1:0] valid);
      return {1'b0, valid[0]} + {1'b0, valid[1]};
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode/hazard/issue-facing signal bundle of the issue queue.
interface issue_queue_if #(
   parameter int unsigned DATA_W = 64
);
   logic [1:0]             in_valid;
   logic [1:0][DATA_W-1:0] in_data;
   logic                   stall;
   logic                   flush;
   logic [1:0]             deq_num;
   logic [1:0]             out_valid;
   logic [1:0][DATA_W-1:0] out_data;
   logic                   overflow;
   logic                   empty;

   modport master (
      output in_valid, in_data, stall, flush, deq_num,
      input  out_valid, out_data, overflow, empty
   );

   modport slave (
      input  in_valid, in_data, stall, flush, deq_num,
      output out_valid, out_data, overflow, empty
   );
endinterface

// File: rtl/issue_queue_ram.sv
// Entry storage: two write ports at tail/tail+1, two asynchronous read ports at head/head+1.
module issue_queue_ram #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we0,
   input  logic [ADDR_W-1:0] waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write addresses always differ when both ports fire (tail vs tail+1).
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/issue_queue.sv
// Circular dual-lane FIFO between decode and issue; presents the two oldest entries to issue.
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = IQ_DEPTH,
   parameter int unsigned DATA_W = IQ_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   issue_queue_if.slave q
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]   headQ, headD, tailQ, tailD;
   logic [CntW-1:0]   countQ, countD;
   logic              accept;
   logic [1:0]        enqN, deqReq, deqN;
   logic              we0, we1;
   logic [DATA_W-1:0] wdata0;

   assign q.out_valid = {countQ >= CntW'(2), countQ >= CntW'(1)};
   assign q.overflow  = countQ >= CntW'(DEPTH - 1);
   assign q.empty     = countQ == '0;

   assign accept = !q.overflow && !q.flush;
   assign enqN   = accept ? laneCount(q.in_valid) : 2'd0;

   // Compact valid lanes so the oldest valid payload always lands at tail.
   assign we0    = accept && (q.in_valid != 2'b00);
   assign we1    = accept && (q.in_valid == 2'b11);
   assign wdata0 = q.in_valid[0] ? q.in_data[0] : q.in_data[1];

   assign deqReq = (q.deq_num == 2'd3) ? 2'd2 : q.deq_num;

   always_comb begin
      deqN = 2'd0;
      if (!q.stall && !q.flush) begin
         deqN = (CntW'(deqReq) > countQ) ? countQ[1:0] : deqReq;
      end
   end

   assign headD  = headQ + PtrW'(deqN);
   assign tailD  = tailQ + PtrW'(enqN);
   assign countD = countQ + CntW'(enqN) - CntW'(deqN);

   always_ff @(posedge clk) begin
      if (reset || q.flush) begin
         headQ  <= '0;
         tailQ  <= '0;
         countQ <= '0;
      end else begin
         headQ  <= headD;
         tailQ  <= tailD;
         countQ <= countD;
      end
   end

   issue_queue_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (PtrW)
   ) u_iq_ram (
      .clk    (clk),
      .we0    (we0),
      .waddr0 (tailQ),
      .wdata0 (wdata0),
      .we1    (we1),
      .waddr1 (tailQ + PtrW'(1)),
      .wdata1 (q.in_data[1]),
      .raddr0 (headQ),
      .rdata0 (q.out_data[0]),
      .raddr1 (headQ + PtrW'(1)),
      .rdata1 (q.out_data[1])
   );

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue with hand-computed expectations.
module tb_issue_queue;

   logic clk;
   logic reset;
   int   nChecks;
   int   nBad;
   int   clipCnt;

   issue_queue_if #(.DATA_W(64)) iqIf ();

   issue_queue #(
      .DEPTH  (8),
      .DATA_W (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .q     (iqIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] dat(input int n);
      return 64'hC0DE_0000_0000_0000 | 64'(n);
   endfunction

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic checkState(input string tag, input int cnt, input logic [1:0] ov,
                             input logic ovf, input logic emp);
      checkVal({tag, ".count"}, 64'(dut.countQ), 64'(cnt));
      checkVal({tag, ".out_valid"}, 64'(iqIf.out_valid), 64'(ov));
      checkVal({tag, ".overflow"}, 64'(iqIf.overflow), 64'(ovf));
      checkVal({tag, ".empty"}, 64'(iqIf.empty), 64'(emp));
   endtask

   task automatic step(input logic [1:0] iv, input int a, input int b, input logic [1:0] dn,
                       input logic st, input logic fl);
      iqIf.in_valid   = iv;
      iqIf.in_data[0] = dat(a);
      iqIf.in_data[1] = dat(b);
      iqIf.deq_num    = dn;
      iqIf.stall      = st;
      iqIf.flush      = fl;
      @(posedge clk);
      #1;
      iqIf.in_valid = 2'b00;
      iqIf.deq_num  = 2'd0;
      iqIf.stall    = 1'b0;
      iqIf.flush    = 1'b0;
   endtask

   // Protocol monitor: issue asked for more entries than out_valid advertises.
   always @(posedge clk) begin
      if (reset === 1'b0 && !iqIf.stall && !iqIf.flush) begin
         if ((iqIf.deq_num != 2'd0 && !iqIf.out_valid[0]) ||
             (iqIf.deq_num >= 2'd2 && !iqIf.out_valid[1])) begin
            clipCnt <= clipCnt + 1;
         end
      end
   end

   initial begin
      nChecks       = 0;
      nBad          = 0;
      clipCnt       = 0;
      reset         = 1'b1;
      iqIf.in_valid = 2'b00;
      iqIf.in_data  = '0;
      iqIf.deq_num  = 2'd0;
      iqIf.stall    = 1'b0;
      iqIf.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkState("reset", 0, 2'b00, 1'b0, 1'b1);

      // Two-lane push, visible next cycle.
      step(2'b11, 1, 2, 2'd0, 1'b0, 1'b0);
      checkState("push11", 2, 2'b11, 1'b0, 1'b0);
      checkVal("push11.out0", iqIf.out_data[0], dat(1));
      checkVal("push11.out1", iqIf.out_data[1], dat(2));

      // Fill up to overflow.
      step(2'b11, 3, 4, 2'd0, 1'b0, 1'b0);
      step(2'b11, 5, 6, 2'd0, 1'b0, 1'b0);
      checkState("fill6", 6, 2'b11, 1'b0, 1'b0);
      step(2'b01, 7, 0, 2'd0, 1'b0, 1'b0);
      checkState("fill7", 7, 2'b11, 1'b1, 1'b0);
      step(2'b11, 90, 91, 2'd0, 1'b0, 1'b0);
      checkState("ignored", 7, 2'b11, 1'b1, 1'b0);
      checkVal("ignored.out0", iqIf.out_data[0], dat(1));
      checkVal("ignored.out1", iqIf.out_data[1], dat(2));

      // Drain keeps order.
      step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
      checkState("deq1", 5, 2'b11, 1'b0, 1'b0);
      checkVal("deq1.out0", iqIf.out_data[0], dat(3));
      checkVal("deq1.out1", iqIf.out_data[1], dat(4));
      step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
      checkState("deq2", 3, 2'b11, 1'b0, 1'b0);
      checkVal("deq2.out0", iqIf.out_data[0], dat(5));
      checkVal("deq2.out1", iqIf.out_data[1], dat(6));

      // Simultaneous push/pop across the 7->0 wrap.
      step(2'b11, 8, 9, 2'd2, 1'b0, 1'b0);
      checkState("wrapA", 3, 2'b11, 1'b0, 1'b0);
      checkVal("wrapA.out0", iqIf.out_data[0], dat(7));
      checkVal("wrapA.out1", iqIf.out_data[1], dat(8));
      step(2'b11, 10, 11, 2'd2, 1'b0, 1'b0);
      checkState("wrapB", 3, 2'b11, 1'b0, 1'b0);
      checkVal("wrapB.out0", iqIf.out_data[0], dat(9));
      checkVal("wrapB.out1", iqIf.out_data[1], dat(10));

      // Stall blocks dequeue but not enqueue.
      step(2'b11, 12, 13, 2'd0, 1'b0, 1'b0);
      checkState("pre_stall", 5, 2'b11, 1'b0, 1'b0);
      step(2'b01, 14, 0, 2'd2, 1'b1, 1'b0);
      checkState("stall", 6, 2'b11, 1'b0, 1'b0);
      checkVal("stall.out0", iqIf.out_data[0], dat(9));
      checkVal("stall.out1", iqIf.out_data[1], dat(10));

      // Flush beats push and pop.
      step(2'b11, 50, 51, 2'd2, 1'b0, 1'b1);
      checkState("flush", 0, 2'b00, 1'b0, 1'b1);

      // Over-dequeue clips; lane1-only push lands at head.
      step(2'b01, 15, 0, 2'd0, 1'b0, 1'b0);
      checkState("one", 1, 2'b01, 1'b0, 1'b0);
      checkVal("one.out0", iqIf.out_data[0], dat(15));
      step(2'b00, 0, 0, 2'd2, 1'b0, 1'b0);
      checkState("clip", 0, 2'b00, 1'b0, 1'b1);
      checkVal("clip.flagged", 64'(clipCnt), 64'd1);
      step(2'b10, 0, 16, 2'd0, 1'b0, 1'b0);
      checkState("lane1", 1, 2'b01, 1'b0, 1'b0);
      checkVal("lane1.out0", iqIf.out_data[0], dat(16));

      // deq_num=3 behaves as 2.
      step(2'b11, 19, 20, 2'd0, 1'b0, 1'b0);
      step(2'b00, 0, 0, 2'd3, 1'b0, 1'b0);
      checkState("deq3", 1, 2'b01, 1'b0, 1'b0);
      checkVal("deq3.out0", iqIf.out_data[0], dat(20));

      // Reset mid-operation with concurrent push and flush.
      reset = 1'b1;
      step(2'b11, 30, 31, 2'd1, 1'b0, 1'b1);
      reset = 1'b0;
      checkState("midreset", 0, 2'b00, 1'b0, 1'b1);
      step(2'b01, 32, 0, 2'd0, 1'b0, 1'b0);
      checkState("after_reset", 1, 2'b01, 1'b0, 1'b0);
      checkVal("after_reset.out0", iqIf.out_data[0], dat(32));
      checkVal("clip.total", 64'(clipCnt), 64'd1);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
